// File: rtl/test_vector_gen.sv
// Stimulus generator: binary/Gray/walking-one/down sequences, each vector held HOLD clocks.
// Optional response signature when TVG_SIGNATURE_EN is defined (port list identical either way).
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet, step_idx keeps last value
// RUN    | presenting vectors, busy=1, vec_valid=1
// DONE   | single-cycle done pulse after the last vector
module test_vector_gen #(
  parameter int WIDTH  = 4,
  parameter int HOLD   = 5,
  parameter int RESP_W = 3,
  parameter int SIG_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [RESP_W-1:0] resp,
  output logic [WIDTH-1:0]  vec,
  output logic              vec_valid,
  output logic [WIDTH-1:0]  step_idx,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [HW-1:0]    hold_rem;
  logic [WIDTH-1:0] last_idx;
  logic             accept;
  logic             hold_tc;

  assign accept   = (state == S_IDLE) && start && !stop;
  assign hold_tc  = (hold_rem == '0);
  assign last_idx = (mode_q == 2'b10) ? WIDTH'(WIDTH - 1) : '1;

  // hold_rem is a down-counter: terminal count 0 marks the last hold cycle of a vector
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= 2'b00;
      hold_rem  <= '0;
      step_idx  <= '0;
      busy      <= 1'b0;
      vec_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_q    <= mode;
            hold_rem  <= HOLD_LAST;
            step_idx  <= '0;
            busy      <= 1'b1;
            vec_valid <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            busy      <= 1'b0;
            vec_valid <= 1'b0;
            state     <= S_IDLE;
          end else if (hold_tc) begin
            if (step_idx == last_idx) begin
              busy      <= 1'b0;
              vec_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              step_idx <= step_idx + 1'b1;
              hold_rem <= HOLD_LAST;
            end
          end else begin
            hold_rem <= hold_rem - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          vec_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    vec = '0;
    if (vec_valid) begin
      case (mode_q)
        2'b00:   vec = step_idx;
        2'b01:   vec = step_idx ^ (step_idx >> 1);
        2'b10:   vec = WIDTH'(1) << step_idx;
        default: vec = ~step_idx;
      endcase
    end
  end

`ifdef TVG_SIGNATURE_EN
  logic [SIG_W-1:0] sig_rot;

  // shift-based rotate stays legal for SIG_W == 1
  assign sig_rot = (signature << 1) | (signature >> (SIG_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      signature <= '0;
    end else if (accept) begin
      signature <= '0;
    end else if ((state == S_RUN) && hold_tc) begin
      signature <= sig_rot ^ SIG_W'(resp);
    end
  end
`else
  logic resp_unused;

  assign resp_unused = ^resp;
  assign signature   = '0;
`endif

endmodule

// File: tb/tb_test_vector_gen.sv
// Scoreboard bench for test_vector_gen (WIDTH=4, HOLD=2): stimulus pushes expected vectors,
// a negedge monitor pops and compares whenever vec_valid or done is shown.
module tb_test_vector_gen;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int RW = 3;
  localparam int SW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [RW-1:0] resp;
  logic [W-1:0]  vec;
  logic          vec_valid;
  logic [W-1:0]  step_idx;
  logic          busy;
  logic          done;
  logic [SW-1:0] signature;

  test_vector_gen #(.WIDTH(W), .HOLD(H), .RESP_W(RW), .SIG_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .resp      (resp),
    .vec       (vec),
    .vec_valid (vec_valid),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done),
    .signature (signature)
  );

  typedef struct {
    bit           is_done;
    logic [W-1:0] v;
    logic [W-1:0] idx;
    bit           last;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad   = 0;
  logic [SW-1:0] model_sig;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seq_len(input logic [1:0] m);
    return (m == 2'b10) ? W : (1 << W);
  endfunction

  function automatic logic [W-1:0] ref_vec(input logic [1:0] m, input int b);
    int r;
    case (m)
      2'b00:   r = b;
      2'b01:   r = b ^ (b >> 1);
      2'b10:   r = 1 << b;
      default: r = (1 << W) - 1 - b;
    endcase
    return W'(r);
  endfunction

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (vec_valid === 1'b1 || done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {30'd0, vec_valid, done}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_flag", done, e.is_done);
        if (!e.is_done) begin
          chk("vec", vec, e.v);
          chk("step_idx", step_idx, e.idx);
          chk("busy_run", busy, 1);
          if (e.last) model_sig = ((model_sig << 1) | (model_sig >> (SW - 1))) ^ SW'(resp);
        end else begin
          chk("done_vec", vec, 0);
          chk("done_busy", busy, 0);
          chk("done_valid", vec_valid, 0);
`ifdef TVG_SIGNATURE_EN
          chk("signature", signature, model_sig);
`else
          chk("signature_tied", signature, 0);
`endif
        end
      end
    end
  end

  initial begin
    resp = '0;
    forever begin
      @(posedge clk);
      #1 resp = RW'($urandom);
    end
  end

  // cut < 0: full run; otherwise abort (stop or rst) during valid cycle number cut
  task automatic do_run(input logic [1:0] m, input int cut, input bit use_rst);
    int   cnt   = seq_len(m);
    int   n     = cnt * H;
    int   shown = (cut >= 0 && cut < n) ? cut + 1 : n;
    int   guard = 0;
    exp_t e;
    for (int i = 0; i < shown; i++) begin
      e.is_done = 1'b0;
      e.v       = ref_vec(m, i / H);
      e.idx     = W'(i / H);
      e.last    = ((i % H) == H - 1);
      q.push_back(e);
    end
    if (shown == n && !(cut >= 0 && cut < n)) begin
      e.is_done = 1'b1;
      e.v       = '0;
      e.idx     = '0;
      e.last    = 1'b0;
      q.push_back(e);
    end
    model_sig = '0;
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1 start = 1'b0;
    mode = 2'($urandom_range(3));
    if (cut >= 0 && cut < n) begin
      repeat (cut) begin
        @(posedge clk);
        #1;
      end
      if (use_rst) rst = 1'b1;
      else         stop = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      stop = 1'b0;
      chk("abort_vec", vec, 0);
      chk("abort_valid", vec_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      if (use_rst) begin
        chk("rst_step_idx", step_idx, 0);
        chk("rst_signature", signature, 0);
      end
      chk("abort_drained", q.size(), 0);
      q.delete();
      @(posedge clk);
      #1 chk("abort_no_done", done, 0);
    end else begin
      while (q.size() > 0 && guard < n + 8) begin
        @(posedge clk);
        #1 guard++;
      end
      chk("run_timeout", q.size(), 0);
      q.delete();
      chk("idle_busy", busy, 0);
      chk("idle_valid", vec_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_vec", vec, 0);
      chk("idle_step_idx", step_idx, cnt - 1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'b00;
    model_sig = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vec", vec, 0);
    chk("reset_valid", vec_valid, 0);
    chk("reset_step_idx", step_idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_signature", signature, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_run(2'b00, -1, 1'b0);
    do_run(2'b01, -1, 1'b0);
    do_run(2'b10, -1, 1'b0);
    do_run(2'b11, -1, 1'b0);
    do_run(2'b00, 5 * H, 1'b0);
    do_run(2'b01, 16 * H - 1, 1'b0);

    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_stop_busy", busy, 0);
      chk("start_stop_valid", vec_valid, 0);
      @(posedge clk);
      #1;
    end

    do_run(2'b01, 9 * H + 1, 1'b1);
    do_run(2'b00, -1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      logic [1:0] m;
      int         cut;
      m   = 2'($urandom_range(3));
      cut = ($urandom_range(2) == 0) ? int'($urandom_range(seq_len(m) * H - 1)) : -1;
      do_run(m, cut, bit'($urandom_range(1)));
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
